cpu_trace_buffer: RTL and testbench

Synthesizable, parametrised capture unit that snoops the CPU fetch stream (rom_addr, instruction) into a circular trace memory. It enforces a programmable cycle limit and then asserts halt to freeze the CPU. Captured entries are drained through a registered read port for post-run inspection. It replaces fixed-duration simulation stops with an in-hardware run limit and trace.

---
 rtl/cpu_dbg_pkg.sv | 17 +
 rtl/trace_ram.sv | 37 +++
 rtl/cpu_trace_buffer.sv | 149 ++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared debug-infrastructure types and default widths used by the CPU and its trace unit.
package cpu_dbg_pkg;

    // Default fetch-stream widths, shared with the CPU core.
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_INSTR_W = 32;

    // One trace entry is {rom_addr, instruction}.
    localparam int TRACE_ENTRY_W = DEF_ADDR_W + DEF_INSTR_W;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } trace_state_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x WIDTH, one synchronous write port, one registered read port.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 48,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store the snooped entry at the write address.
    // NOTE: the storage array is deliberately not reset; only the control state and the read register are.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output gives one cycle of read latency and holds between reads.
    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Fetch-stream trace capture with a programmable cycle limit, halt request and drain port.
module cpu_trace_buffer
    import cpu_dbg_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INSTR_W     = DEF_INSTR_W,
    parameter int DEPTH       = 16,
    parameter int CYCLE_LIMIT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       mode_wrap,
    input  logic                       sample_en,
    input  logic [ADDR_W-1:0]          rom_addr,
    input  logic [INSTR_W-1:0]         instruction,
    output logic                       halt,
    output logic                       capturing,
    input  logic                       rd_req,
    output logic                       rd_valid,
    output logic [ADDR_W+INSTR_W-1:0]  rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int ENTRY_W = ADDR_W + INSTR_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_O_W = $clog2(DEPTH + 1);
    localparam logic [CNT_O_W-1:0] FULL_CNT    = CNT_O_W'(DEPTH);
    localparam logic [CNT_O_W-1:0] ALMOST_FULL = CNT_O_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   LAST_CYC    = CNT_W'(CYCLE_LIMIT - 1);

    // Elaboration checks: the pointers rely on power-of-two wrap, and the cycle counter must reach the limit.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("cpu_trace_buffer: DEPTH must be a power of two and at least 2");
    end
    if ((CNT_W < 31) && (CYCLE_LIMIT >= (1 << CNT_W))) begin : g_cnt_w_check
        $error("cpu_trace_buffer: CNT_W is too narrow to count to CYCLE_LIMIT");
    end

    trace_state_t       state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_O_W-1:0] count_q;
    logic [CNT_W-1:0]   cyc_q;
    logic               wrap_q;
    logic               overflow_q;
    logic               halt_q;
    logic               rd_valid_q;

    logic wr_en, rd_en, overwrite, limit_hit, fills;

    // Datapath strobes; arm overrides any write or read in the same cycle.
    always_comb begin
        wr_en     = (state_q == CAPTURE) && sample_en && !arm;
        rd_en     = (state_q == DONE) && rd_req && !arm && (count_q != '0);
        overwrite = wr_en && wrap_q && (count_q == FULL_CNT);
        limit_hit = (CYCLE_LIMIT != 0) && (cyc_q == LAST_CYC);
        fills     = wr_en && !wrap_q && (count_q == ALMOST_FULL);
    end

    // Next-state logic: arm restarts from any state; capture ends at the cycle limit or a stop-mode fill.
    // NOTE: state_d takes its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = CAPTURE;
        end else begin
            case (state_q)
                CAPTURE: if (limit_hit || fills) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers, occupancy, cycle counter, flags and registered halt / read-valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            cyc_q      <= '0;
            wrap_q     <= 1'b0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            halt_q     <= (state_d == DONE);
            rd_valid_q <= rd_en;
            if (arm) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count_q    <= '0;
                cyc_q      <= '0;
                overflow_q <= 1'b0;
                wrap_q     <= mode_wrap;
            end else begin
                if (state_q == CAPTURE) begin
                    cyc_q <= cyc_q + 1'b1;
                end
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (overwrite) begin
                        // Full in wrap mode: the oldest entry is lost, so the read side moves past it.
                        rd_ptr     <= rd_ptr + 1'b1;
                        overflow_q <= 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                if (rd_en) begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (PTR_W)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({rom_addr, instruction}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign halt      = halt_q;
    assign capturing = (state_q == CAPTURE);
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_cpu_trace_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int IW    = 32;
    localparam int EW    = AW + IW;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0, arm_u = 1'b0;
    logic          mode_wrap = 1'b0, sample_en = 1'b0, rd_req = 1'b0;
    logic [AW-1:0] rom_addr = '0;
    logic [IW-1:0] instruction = '0;

    // Index 0: CYCLE_LIMIT=6 instance, index 1: unlimited (CYCLE_LIMIT=0) instance.
    logic          halt_o [2];
    logic          capturing_o [2];
    logic          rd_valid_o [2];
    logic [EW-1:0] rd_data_o [2];
    logic [CW-1:0] count_o [2];
    logic          overflow_o [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    cpu_trace_buffer #(
        .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .CYCLE_LIMIT(6), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .arm(arm), .mode_wrap(mode_wrap),
        .sample_en(sample_en), .rom_addr(rom_addr), .instruction(instruction),
        .halt(halt_o[0]), .capturing(capturing_o[0]), .rd_req(rd_req),
        .rd_valid(rd_valid_o[0]), .rd_data(rd_data_o[0]), .count(count_o[0]),
        .overflow(overflow_o[0])
    );

    cpu_trace_buffer #(
        .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .CYCLE_LIMIT(0), .CNT_W(16)
    ) dut_u (
        .clock(clock), .reset(reset), .arm(arm_u), .mode_wrap(mode_wrap),
        .sample_en(sample_en), .rom_addr(rom_addr), .instruction(instruction),
        .halt(halt_o[1]), .capturing(capturing_o[1]), .rd_req(rd_req),
        .rd_valid(rd_valid_o[1]), .rd_data(rd_data_o[1]), .count(count_o[1]),
        .overflow(overflow_o[1])
    );

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_CAP, M_DONE} mphase_e;
    mphase_e       ms [2];
    logic [EW-1:0] mq [2][$];
    int            mcyc [2];
    bit            mwrap [2];
    bit            movf [2];
    bit            mrv [2];
    logic [EW-1:0] mrd [2];
    int            lim [2] = '{6, 0};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ms[k]   = M_IDLE;
            mq[k].delete();
            mcyc[k] = 0;
            mwrap[k] = 0;
            movf[k] = 0;
            mrv[k]  = 0;
            mrd[k]  = '0;
        end
    endtask

    task automatic model_step(input int k, input bit a);
        bit stop;
        mrv[k] = 0;
        if (a) begin
            mq[k].delete();
            movf[k]  = 0;
            mcyc[k]  = 0;
            mwrap[k] = mode_wrap;
            ms[k]    = M_CAP;
        end else if (ms[k] == M_CAP) begin
            stop = (lim[k] != 0) && (mcyc[k] == lim[k] - 1);
            if (sample_en) begin
                if (mq[k].size() == DEPTH) begin
                    void'(mq[k].pop_front());
                    movf[k] = 1;
                end
                mq[k].push_back({rom_addr, instruction});
                if (!mwrap[k] && mq[k].size() == DEPTH) stop = 1;
            end
            mcyc[k]++;
            if (stop) ms[k] = M_DONE;
        end else if (ms[k] == M_DONE && rd_req && mq[k].size() > 0) begin
            mrd[k] = mq[k].pop_front();
            mrv[k] = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("halt[%0d]", k),      64'(halt_o[k]),      64'(ms[k] == M_DONE));
            check($sformatf("capturing[%0d]", k), 64'(capturing_o[k]), 64'(ms[k] == M_CAP));
            check($sformatf("rd_valid[%0d]", k),  64'(rd_valid_o[k]),  64'(mrv[k]));
            check($sformatf("rd_data[%0d]", k),   64'(rd_data_o[k]),   64'(mrd[k]));
            check($sformatf("count[%0d]", k),     64'(count_o[k]),     64'(mq[k].size()));
            check($sformatf("overflow[%0d]", k),  64'(overflow_o[k]),  64'(movf[k]));
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare 1 time unit after the edge.
    task automatic tick(input bit a, input bit au, input bit se, input bit rr, input bit mw,
                        input logic [AW-1:0] ad);
        arm = a; arm_u = au; sample_en = se; rd_req = rr; mode_wrap = mw;
        rom_addr = ad; instruction = $urandom();
        @(posedge clock);
        model_step(0, a);
        model_step(1, au);
        #1 check_all();
        @(negedge clock);
    endtask

    task automatic drain_expect(input string tag, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            tick(0, 0, 0, 1, mode_wrap, '0);
            check({tag, "_valid"}, 64'(rd_valid_o[0]), 64'd1);
            check({tag, "_addr"},  64'(rd_data_o[0][EW-1:IW]), 64'(first + i));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        check_all();
        reset = 1'b0;

        // 1. reset in the middle of a capture
        tick(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 0, AW'(i));
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        check("t1_count", 64'(count_o[0]), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        tick(0, 0, 0, 1, 0, '0);
        check("t1_idle", 64'(capturing_o[0]), 64'd0);

        // 2. stop mode fills the buffer
        tick(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            check("t2_halt_low", 64'(halt_o[0]), 64'd0);
            tick(0, 0, 1, 0, 0, AW'(i));
        end
        check("t2_halt", 64'(halt_o[0]), 64'd1);
        check("t2_count", 64'(count_o[0]), 64'd4);
        drain_expect("t2_pop", 0, 4);
        tick(0, 0, 0, 1, 0, '0);
        check("t2_empty_pop", 64'(rd_valid_o[0]), 64'd0);

        // 3. wrap mode runs to the cycle limit with overwrite
        tick(1, 0, 0, 0, 1, '0);
        for (int i = 0; i < 6; i++) tick(0, 0, 1, 0, 1, AW'(i));
        check("t3_halt", 64'(halt_o[0]), 64'd1);
        check("t3_overflow", 64'(overflow_o[0]), 64'd1);
        check("t3_count", 64'(count_o[0]), 64'd4);
        drain_expect("t3_pop", 2, 4);

        // 4. sparse samples in wrap mode
        tick(1, 0, 0, 0, 1, '0);
        for (int i = 0; i < 6; i++) begin
            check("t4_not_done", 64'(halt_o[0]), 64'd0);
            tick(0, 0, (i % 2) == 0, 0, 1, AW'(10 + i / 2));
        end
        check("t4_halt", 64'(halt_o[0]), 64'd1);
        check("t4_count", 64'(count_o[0]), 64'd3);
        check("t4_overflow", 64'(overflow_o[0]), 64'd0);
        drain_expect("t4_pop", 10, 3);

        // 5. arm beats rd_req while DONE
        tick(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 6; i++) tick(0, 0, i < 2, 0, 0, AW'(i));
        check("t5_halt", 64'(halt_o[0]), 64'd1);
        check("t5_count", 64'(count_o[0]), 64'd2);
        tick(1, 0, 0, 1, 0, '0);
        check("t5_count0", 64'(count_o[0]), 64'd0);
        check("t5_halt0", 64'(halt_o[0]), 64'd0);
        check("t5_capturing", 64'(capturing_o[0]), 64'd1);
        check("t5_rd_valid", 64'(rd_valid_o[0]), 64'd0);

        // 6. unlimited wrap capture never halts
        tick(0, 1, 0, 0, 1, '0);
        for (int i = 0; i < 100; i++) tick(0, 0, 1, 1'($urandom_range(0, 1)), 1, AW'($urandom()));
        check("t6_halt", 64'(halt_o[1]), 64'd0);
        check("t6_capturing", 64'(capturing_o[1]), 64'd1);
        check("t6_overflow", 64'(overflow_o[1]), 64'd1);
        check("t6_count", 64'(count_o[1]), 64'd4);
        check("t6_rd_valid", 64'(rd_valid_o[1]), 64'd0);

        // Random traffic on both instances against the model.
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), AW'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
